binary_morph_filter: RTL
========================

Name: binary_morph_filter

Overview:
- Streaming 3x3 morphological filter for the 1-bit thresholded pixel stream in the IPU.
- Sits between the binarisation stage and the downstream blob/centroid logic.
- Performs one erosion or dilation pass per instance, with a selectable structuring element.
- Opening and closing are built by cascading two instances in opposite modes; each instance also reports a per-frame count of set output pixels.

Parameters:
- IMG_WIDTH, 640, active pixels per line; sets line-buffer depth.
- SHAPE, 0, structuring element: 0 = 3x3 square (8-neighbour), 1 = cross (4-neighbour plus centre).
- DEFAULT_MODE, 2'b00, mode loaded into the mode register at reset.
- CNT_W, 20, width of the per-frame set-pixel counter.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous active-low reset.
- iBinary  in  1  input pixel.
- iDVAL  in  1  input pixel valid, one pixel per beat; back-to-back beats and gaps are both legal.
- iX_Cont  in  16  input column, 0..IMG_WIDTH-1.
- iY_Cont  in  16  input row.
- iFrame_En  in  1  frame enable; beats are ignored while low.
- iMode  in  2  00 bypass, 01 erode, 10 dilate, 11 bypass.
- oDCLEAN  out  1  filtered pixel.
- oDVAL  out  1  output valid.
- oX_Cont  out  16  column of the output centre pixel.
- oY_Cont  out  16  row of the output centre pixel.
- oPixCount  out  CNT_W  number of oDCLEAN=1 outputs in the previous frame.
- oFrameDone  out  1  one-cycle pulse when oPixCount updates.

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST is asynchronous, active-low.
- Reset values:
  - oDCLEAN, oDVAL, oX_Cont, oY_Cont, oPixCount, oFrameDone, pipeline valids and the running counter all reset to 0.
  - The mode register resets to DEFAULT_MODE.
  - Line-buffer RAM contents are not reset; the padding rules below make stale contents irrelevant.
- Accepted beat: a beat counts only when iDVAL=1 and iFrame_En=1. With iFrame_En=0, nothing is written, no output is produced, and the counter holds.
- Storage:
  - Two line buffers, each IMG_WIDTH x 1 bit, addressed by iX_Cont, holding rows y-1 and y-2.
  - On each accepted beat, both buffers are read at column x and the row chain is shifted: the new pixel goes to buffer 1 and the old buffer-1 bit goes to buffer 2.
  - Three 3-deep column shift registers form a window over rows y-2..y and columns x-2..x.
- Output mapping:
  - An accepted beat at (x,y) with x>=1 and y>=1 yields the result for centre (x-1,y-1).
  - Beats with x=0 or y=0 produce no output (oDVAL stays 0).
  - The output frame is therefore (IMG_WIDTH-1) x (H-1); the last input row and column are never centres.
- Padding: window taps outside the frame take the identity value, 1 for erode and 0 for dilate.
  - Left column: taps at column x-2 when x=1.
  - Top row: taps at row y-2 when y=1.
- Operations:
  - Erode: result = AND of the taps selected by SHAPE.
  - Dilate: result = OR of the same taps.
  - Bypass: result = the centre tap.
- Latency: fixed at 2 cycles. Accepted beat at cycle t gives oDVAL=1 at t+2, with oX_Cont=x-1 and oY_Cont=y-1. Full throughput of one pixel per cycle, no stalls.
- Mode latch: iMode is sampled only on an accepted beat at (0,0). A mode change mid-frame takes effect at the next frame start.
- Pixel count:
  - The running counter increments on each output with oDCLEAN=1.
  - On an accepted beat at (0,0) with y_prev != 0: oPixCount is loaded with the running total, oFrameDone pulses 1 cycle later, and the counter clears. If an output with oDCLEAN=1 coincides with the clear, it counts toward the new frame.
  - The counter saturates at 2^CNT_W-1.
- Frame restart: a restart (iY_Cont returning to 0) mid-frame restarts the padding and mapping rules; in-flight pipeline outputs still emerge.
- Reset mid-frame: all pipeline state is discarded immediately. The first valid output after reset requires a new row y>=1 following a row 0, i.e. the next frame.

Test Plan (IMG_WIDTH=8, 6-row frames, back-to-back beats):
- Reset with iRST=0, then release -> all outputs 0; the first beat at (0,0) with iMode=00 latches bypass; a beat at (3,2) with pixel 1 gives oDVAL=1 two cycles after the beat at (4,3), with oX=3, oY=2, oDCLEAN=1.
- Erode, SHAPE=0, single 1 at (3,2) in an all-zero frame -> every output is 0; a 3x3 block of ones centred at (3,2) gives exactly one 1 at (3,2); next frame oPixCount=1 with a one-cycle oFrameDone pulse.
- Dilate, SHAPE=1, single 1 at (4,3) -> ones exactly at (4,3), (3,3), (5,3), (4,2), (4,4); oPixCount=5.
- Erode, all-ones frame -> all 35 outputs are 1 (identity padding, no border loss); oPixCount=35. Same frame in dilate with all zeros -> oPixCount=0.
- Drop iMode mid-frame from 01 to 10 -> the current frame stays erode and dilate starts at the next (0,0). Deassert iFrame_En for 5 cycles mid-row -> no oDVAL and no buffer writes; results resume correctly afterwards.
- Assert iRST during row 3 -> outputs go to 0 asynchronously and oPixCount=0; the following frame's outputs match the golden model exactly.

Source files
------------

// File: rtl/binary_morph_filter_if.sv
// Pixel-stream bundle between the binarisation stage and the morphological filter.
// The master drives the thresholded pixel stream and the slave returns the filtered stream and frame statistics.
interface binary_morph_filter_if #(
  parameter int CNT_W = 20
);
  logic              iBinary;
  logic              iDVAL;
  logic [15:0]       iX_Cont;
  logic [15:0]       iY_Cont;
  logic              iFrame_En;
  logic [1:0]        iMode;
  logic              oDCLEAN;
  logic              oDVAL;
  logic [15:0]       oX_Cont;
  logic [15:0]       oY_Cont;
  logic [CNT_W-1:0]  oPixCount;
  logic              oFrameDone;

  modport master (
    output iBinary, iDVAL, iX_Cont, iY_Cont, iFrame_En, iMode,
    input  oDCLEAN, oDVAL, oX_Cont, oY_Cont, oPixCount, oFrameDone
  );

  modport slave (
    input  iBinary, iDVAL, iX_Cont, iY_Cont, iFrame_En, iMode,
    output oDCLEAN, oDVAL, oX_Cont, oY_Cont, oPixCount, oFrameDone
  );
endinterface

// File: rtl/binary_morph_filter.sv
// Streaming 3x3 binary erosion/dilation with two line buffers, identity padding at the
// top/left frame edges, and a saturating per-frame count of set output pixels.
module binary_morph_filter #(
  parameter int         IMG_WIDTH    = 640,
  parameter int         SHAPE        = 0,
  parameter logic [1:0] DEFAULT_MODE = 2'b00,
  parameter int         CNT_W        = 20
) (
  input logic                  iCLK,
  input logic                  iRST,
  binary_morph_filter_if.slave bus
);

  localparam logic [1:0]       MODE_ERODE  = 2'b01;
  localparam logic [1:0]       MODE_DILATE = 2'b10;
  localparam int               AW          = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_ONE;
    return v;
  endfunction

  // Columns are packed {row y, row y-1, row y-2}; padded taps take the operation's identity.
  function automatic logic morph(input logic [2:0] c_l, input logic [2:0] c_m,
                                 input logic [2:0] c_r, input logic [1:0] m,
                                 input logic pl, input logic pt);
    logic       id;
    logic [2:0] l, c, r;
    logic [8:0] sq;
    logic [4:0] cr;
    id = (m == MODE_ERODE);
    l  = pl ? {3{id}} : c_l;
    c  = c_m;
    r  = c_r;
    if (pt) begin
      l[0] = id;
      c[0] = id;
      r[0] = id;
    end
    sq = {l, c, r};
    cr = {c[0], l[1], c[1], r[1], c[2]};
    case (m)
      MODE_ERODE:  morph = (SHAPE == 1) ? (&cr) : (&sq);
      MODE_DILATE: morph = (SHAPE == 1) ? (|cr) : (|sq);
      default:     morph = c[1];
    endcase
  endfunction

  logic          lb1_mem [IMG_WIDTH];
  logic          lb2_mem [IMG_WIDTH];

  logic          acc_p0, origin_p0, row1_p0, row2_p0;
  logic [AW-1:0] addr_p0;

  logic [1:0]    mode_q, mode_d;
  logic          armed_q, armed_d;
  logic [15:0]   y_prev_q, y_prev_d;
  logic          vld_p1_q, vld_p1_d;
  logic          load_p1_q, load_p1_d;
  logic [2:0]    col_x_p1_q, col_x_p1_d, col_x1_p1_q, col_x1_p1_d, col_x2_p1_q, col_x2_p1_d;
  logic [15:0]   cx_p1_q, cx_p1_d, cy_p1_q, cy_p1_d;
  logic          pad_left_p1_q, pad_left_p1_d, pad_top_p1_q, pad_top_p1_d;

  logic          res_p1;
  logic          dval_p2_q, dval_p2_d, dclean_p2_q, dclean_p2_d;
  logic [15:0]   ox_p2_q, ox_p2_d, oy_p2_q, oy_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pix_count_q, pix_count_d;
  logic          frame_done_q, frame_done_d;

  // Stage p0: accept beat, read both line buffers at the incoming column.
  assign acc_p0    = bus.iDVAL & bus.iFrame_En;
  assign origin_p0 = acc_p0 && (bus.iX_Cont == 16'd0) && (bus.iY_Cont == 16'd0);
  assign addr_p0   = bus.iX_Cont[AW-1:0];
  assign row1_p0   = lb1_mem[addr_p0];
  assign row2_p0   = lb2_mem[addr_p0];

  always_ff @(posedge iCLK) begin
    if (acc_p0) begin
      lb1_mem[addr_p0] <= bus.iBinary;
      lb2_mem[addr_p0] <= row1_p0;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    armed_d   = armed_q;
    y_prev_d  = y_prev_q;
    vld_p1_d  = 1'b0;
    load_p1_d = 1'b0;
    if (acc_p0) begin
      y_prev_d = bus.iY_Cont;
      vld_p1_d = armed_q && (bus.iX_Cont != 16'd0) && (bus.iY_Cont != 16'd0);
      if (origin_p0) begin
        mode_d    = bus.iMode;
        armed_d   = 1'b1;
        load_p1_d = (y_prev_q != 16'd0);
      end
    end
  end

  always_comb begin
    col_x_p1_d    = col_x_p1_q;
    col_x1_p1_d   = col_x1_p1_q;
    col_x2_p1_d   = col_x2_p1_q;
    cx_p1_d       = cx_p1_q;
    cy_p1_d       = cy_p1_q;
    pad_left_p1_d = pad_left_p1_q;
    pad_top_p1_d  = pad_top_p1_q;
    if (acc_p0) begin
      col_x_p1_d    = {bus.iBinary, row1_p0, row2_p0};
      col_x1_p1_d   = col_x_p1_q;
      col_x2_p1_d   = col_x1_p1_q;
      cx_p1_d       = bus.iX_Cont - 16'd1;
      cy_p1_d       = bus.iY_Cont - 16'd1;
      pad_left_p1_d = (bus.iX_Cont == 16'd1);
      pad_top_p1_d  = (bus.iY_Cont == 16'd1);
    end
  end

  // Stage p1 -> p2: evaluate the window, register outputs and frame statistics.
  assign res_p1 = morph(col_x2_p1_q, col_x1_p1_q, col_x_p1_q, mode_q, pad_left_p1_q, pad_top_p1_q);

  always_comb begin
    dval_p2_d    = vld_p1_q;
    dclean_p2_d  = vld_p1_q & res_p1;
    ox_p2_d      = vld_p1_q ? cx_p1_q : ox_p2_q;
    oy_p2_d      = vld_p1_q ? cy_p1_q : oy_p2_q;
    pix_count_d  = pix_count_q;
    frame_done_d = load_p1_q;
    if (load_p1_q) begin
      pix_count_d = cnt_q;
      cnt_d       = sat_inc('0, vld_p1_q & res_p1);
    end else begin
      cnt_d       = sat_inc(cnt_q, vld_p1_q & res_p1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      mode_q       <= DEFAULT_MODE;
      armed_q      <= 1'b0;
      y_prev_q     <= '0;
      vld_p1_q     <= 1'b0;
      load_p1_q    <= 1'b0;
      dval_p2_q    <= 1'b0;
      dclean_p2_q  <= 1'b0;
      ox_p2_q      <= '0;
      oy_p2_q      <= '0;
      cnt_q        <= '0;
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      armed_q      <= armed_d;
      y_prev_q     <= y_prev_d;
      vld_p1_q     <= vld_p1_d;
      load_p1_q    <= load_p1_d;
      dval_p2_q    <= dval_p2_d;
      dclean_p2_q  <= dclean_p2_d;
      ox_p2_q      <= ox_p2_d;
      oy_p2_q      <= oy_p2_d;
      cnt_q        <= cnt_d;
      pix_count_q  <= pix_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge iCLK) begin
    col_x_p1_q    <= col_x_p1_d;
    col_x1_p1_q   <= col_x1_p1_d;
    col_x2_p1_q   <= col_x2_p1_d;
    cx_p1_q       <= cx_p1_d;
    cy_p1_q       <= cy_p1_d;
    pad_left_p1_q <= pad_left_p1_d;
    pad_top_p1_q  <= pad_top_p1_d;
  end

  assign bus.oDCLEAN    = dclean_p2_q;
  assign bus.oDVAL      = dval_p2_q;
  assign bus.oX_Cont    = ox_p2_q;
  assign bus.oY_Cont    = oy_p2_q;
  assign bus.oPixCount  = pix_count_q;
  assign bus.oFrameDone = frame_done_q;

endmodule
